// File: rtl/ej2_seq_if.sv
// Handshake and strobe bundle between the ej2 timing-signal sequencer and its controller.
interface ej2_seq_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             hold;
  logic [CNT_W-1:0] loop_count;
  logic [3:0]       step_mask;
  logic [3:0]       t;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_idx;

  modport master (
    output start, hold, loop_count, step_mask,
    input  t, busy, done, pass_idx
  );

  modport slave (
    input  start, hold, loop_count, step_mask,
    output t, busy, done, pass_idx
  );
endinterface

// File: rtl/ej2_sequencer.sv
// One-hot T0..T3 strobe generator for the ej2 datapath, run for a programmable number of passes.
// Macro EJ2_SEQ_MASK_EN: when defined step_mask selects the enabled steps, otherwise all four run.
module ej2_sequencer #(
  parameter int CNT_W = 4
) (
  input logic      clk,
  input logic      rst_n,
  ej2_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [3:0]       mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [1:0]       cur_q, cur_d;

  logic [3:0]       start_mask;
  logic [3:0]       higher;
  logic [CNT_W:0]   pass_nx;
  logic [CNT_W:0]   eff_cnt;

  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic logic [3:0] bits_above(input logic [3:0] m, input logic [1:0] c);
    logic [3:0] keep;
    keep = 4'b1110 << c;
    return m & keep;
  endfunction

`ifdef EJ2_SEQ_MASK_EN
  assign start_mask = bus.step_mask;
`else
  assign start_mask = 4'b1111;
`endif

  assign higher  = bits_above(mask_q, cur_q);
  assign pass_nx = {1'b0, pass_q} + {{CNT_W{1'b0}}, 1'b1};
  // A programmed count of zero still runs a single pass.
  assign eff_cnt = (cnt_q == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, cnt_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= 4'b0000;
      cnt_q   <= '0;
      pass_q  <= '0;
      cur_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    cur_d   = cur_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mask_d = start_mask;
          cnt_d  = bus.loop_count;
          pass_d = '0;
          cur_d  = lowest_bit(start_mask);
`ifdef EJ2_SEQ_MASK_EN
          state_d = (start_mask != 4'b0000) ? S_RUN : S_DONE;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN: begin
        if (!bus.hold) begin
          if (higher != 4'b0000) begin
            cur_d = lowest_bit(higher);
          end else if (pass_nx < eff_cnt) begin
            pass_d = pass_nx[CNT_W-1:0];
            cur_d  = lowest_bit(mask_q);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.t        = 4'b0000;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.pass_idx = pass_q;
    unique case (state_q)
      S_RUN: begin
        bus.busy = 1'b1;
        if (!bus.hold) bus.t = 4'b0001 << cur_q;
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ej2_sequencer.sv
// Directed bench for ej2_sequencer: vector table of full runs plus hold, start-ignore and reset sequences.
module tb_ej2_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ej2_seq_if #(.CNT_W(4)) bus ();

  ej2_sequencer #(.CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      mask;
    logic [3:0]      lc;
    logic [3:0][3:0] seq;
    int              nstep;
    int              npass;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cycle(input string nm, input logic [3:0] t, input logic [3:0] pidx,
                           input logic busy, input logic done);
    @(negedge clk);
    chk({nm, ".t"}, bus.t, t);
    chk({nm, ".pass"}, bus.pass_idx, pidx);
    chk({nm, ".busy"}, bus.busy, busy);
    chk({nm, ".done"}, bus.done, done);
  endtask

  task automatic launch(input logic [3:0] mask, input logic [3:0] lc);
    bus.start      = 1'b1;
    bus.step_mask  = mask;
    bus.loop_count = lc;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start      = 1'b0;
    bus.hold       = 1'b0;
    bus.loop_count = 4'd0;
    bus.step_mask  = 4'b0000;

    vt[0] = '{4'b1111, 4'd1,  {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4, 1};
    vt[5] = '{4'b1111, 4'd15, {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4, 15};
`ifdef EJ2_SEQ_MASK_EN
    vt[1] = '{4'b0101, 4'd3,  {4'b0000, 4'b0000, 4'b0100, 4'b0001}, 2, 3};
    vt[2] = '{4'b0000, 4'd5,  {4'b0000, 4'b0000, 4'b0000, 4'b0000}, 0, 1};
    vt[3] = '{4'b1010, 4'd0,  {4'b0000, 4'b0000, 4'b1000, 4'b0010}, 2, 1};
    vt[4] = '{4'b1000, 4'd2,  {4'b0000, 4'b0000, 4'b0000, 4'b1000}, 1, 2};
`else
    vt[1] = '{4'b0101, 4'd3,  {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4, 3};
    vt[2] = '{4'b0000, 4'd5,  {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4, 5};
    vt[3] = '{4'b1010, 4'd0,  {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4, 1};
    vt[4] = '{4'b1000, 4'd2,  {4'b1000, 4'b0100, 4'b0010, 4'b0001}, 4, 2};
`endif

    tick();
    tick();
    chk_cycle("reset", 4'b0000, 4'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    chk_cycle("idle", 4'b0000, 4'd0, 1'b0, 1'b0);

    // Table-driven full runs: strobes, done pulse, then back to IDLE.
    for (int v = 0; v < 6; v++) begin
      launch(vt[v].mask, vt[v].lc);
      for (int p = 0; p < vt[v].npass; p++) begin
        for (int s = 0; s < vt[v].nstep; s++) begin
          chk_cycle($sformatf("vec%0d.p%0d.s%0d", v, p, s), vt[v].seq[s], 4'(p), 1'b1, 1'b0);
          tick();
        end
      end
      @(negedge clk);
      chk($sformatf("vec%0d.done", v), bus.done, 1'b1);
      chk($sformatf("vec%0d.done_busy", v), bus.busy, 1'b0);
      chk($sformatf("vec%0d.done_t", v), bus.t, 4'b0000);
      tick();
      chk_cycle($sformatf("vec%0d.idle", v), 4'b0000, 4'(vt[v].npass - 1), 1'b0, 1'b0);
      tick();
    end

    // Hold for three cycles while T1 is current.
    launch(4'b1111, 4'd1);
    chk_cycle("hold.t0", 4'b0001, 4'd0, 1'b1, 1'b0);
    tick();
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_cycle($sformatf("hold.h%0d", i), 4'b0000, 4'd0, 1'b1, 1'b0);
      tick();
    end
    bus.hold = 1'b0;
    chk_cycle("hold.t1", 4'b0010, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("hold.t2", 4'b0100, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("hold.t3", 4'b1000, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("hold.done", 4'b0000, 4'd0, 1'b0, 1'b1);
    tick();
    chk_cycle("hold.idle", 4'b0000, 4'd0, 1'b0, 1'b0);
    tick();

    // Start pulses in RUN and DONE are ignored; start in the next IDLE is taken.
    launch(4'b1111, 4'd1);
    chk_cycle("ign.t0", 4'b0001, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start = 1'b1;
    chk_cycle("ign.t1", 4'b0010, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start = 1'b0;
    chk_cycle("ign.t2", 4'b0100, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("ign.t3", 4'b1000, 4'd0, 1'b1, 1'b0);
    tick();
    bus.start = 1'b1;
    chk_cycle("ign.done", 4'b0000, 4'd0, 1'b0, 1'b1);
    tick();
    chk_cycle("ign.idle", 4'b0000, 4'd0, 1'b0, 1'b0);
    tick();
    bus.start = 1'b0;
    chk_cycle("reacc.t0", 4'b0001, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("reacc.t1", 4'b0010, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("reacc.t2", 4'b0100, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("reacc.t3", 4'b1000, 4'd0, 1'b1, 1'b0);
    tick();
    chk_cycle("reacc.done", 4'b0000, 4'd0, 1'b0, 1'b1);
    tick();
    chk_cycle("reacc.idle", 4'b0000, 4'd0, 1'b0, 1'b0);
    tick();

    // Reset during T2 of pass 1 aborts silently.
    launch(4'b1111, 4'd3);
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    chk_cycle("rst.pre", 4'b0100, 4'd1, 1'b1, 1'b0);
    tick();
    rst_n = 1'b1;
    chk_cycle("rst.post", 4'b0000, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_cycle($sformatf("rst.quiet%0d", i), 4'b0000, 4'd0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ej2_sequencer.md
# ej2_sequencer

Timing-signal controller for the `ej2` four-step register-transfer datapath. It generates the one-hot control strobes T0..T3 that drive `ej2`'s `control[0..3]` inputs, so the testbench no longer has to hand-write the control pattern. A start/done handshake launches a programmable number of passes over the enabled steps. A hold input freezes the sequence mid-pass without losing its position.

## Interface
- `CNT_W`, default 4: width of the pass counter and of `loop_count` / `pass_idx`.
- `clk  in  1`: rising-edge clock, shared with `ej2`.
- `rst_n  in  1`: reset, synchronous, active-low.
- `start  in  1`: launch request; accepted only in IDLE.
- `hold  in  1`: freeze request while running.
- `loop_count  in  CNT_W`: number of passes, sampled on accepted start; 0 means 1 pass.
- `step_mask  in  4`: bit i set enables step Ti; sampled on accepted start.
- `t  out  4`: one-hot timing strobes, bit i = Ti, connected to `ej2` `control[i]`.
- `busy  out  1`: high in RUN.
- `done  out  1`: one-cycle completion pulse.
- `pass_idx  out  CNT_W`: index of the current pass, 0-based.

## Operation
- FSM has three states.
  - IDLE: `t`=0, `busy`=0, `done`=0.
  - RUN: stepping through the enabled steps.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- IDLE → RUN on `start`=1 when the sampled mask is nonzero. On entry, latch `step_mask` and `loop_count`, set `pass_idx`=0, and set the current step to the lowest enabled bit.
- IDLE → DONE on `start`=1 with a sampled mask of 0. This gives a done pulse with no strobes.
- In RUN, `t` is the one-hot of the current step, gated by `hold`: `t = hold ? 0 : onehot(cur)`. `t` is combinational from registered state and the `hold` input.
- Stepping rules in RUN, for a cycle with `hold`=0:
  - The current step advances to the next higher enabled bit.
  - After the highest enabled bit, if `pass_idx` + 1 is less than the effective count, increment `pass_idx` and wrap to the lowest enabled bit.
  - Otherwise go to DONE.
- Effective count is `loop_count`, with 0 mapped to 1.
- In RUN with `hold`=1: state, current step and `pass_idx` are frozen. The held step is strobed on the first cycle after `hold` is released.
- `start` is ignored in RUN and in DONE. There is no queuing.
- Changes to `step_mask` or `loop_count` after start have no effect until the next accepted start.
- Width rules:
  - `pass_idx` never exceeds count−1, so no wrap-around of the pass counter.
  - A count of 2^CNT_W−1 is the maximum number of passes.
- `rst_n`=0 at any clock edge, including mid-pass or during hold, forces IDLE. All outputs are 0 on the next cycle and the latched configuration is cleared.

## Timing
- Reset values: `t`=0000, `busy`=0, `done`=0, `pass_idx`=0.
- Start accepted at edge k gives the first strobe in cycle k+1. Each enabled step lasts one cycle when unheld.
- Total RUN cycles = popcount(mask) × passes + cycles with `hold`=1.
- `done` is asserted the cycle after the last strobe. IDLE follows the next cycle, and a new `start` is accepted in that IDLE cycle.
- Minimum start-to-start spacing is RUN cycles + 2.
- Exactly one bit of `t` is high in any cycle of RUN with `hold`=0. `t` is always 0 outside RUN.

## Configuration
- `EJ2_SEQ_MASK_EN` defined:
  - `step_mask` is honoured as described above.
  - The zero-mask start goes straight to DONE.
- `EJ2_SEQ_MASK_EN` undefined:
  - `step_mask` is ignored and the latched mask is forced to 4'b1111.
  - Every pass strobes T0, T1, T2, T3 in order.
  - The zero-mask path does not exist.

## Test plan
- Reset then start, mask=1111, loop_count=1: `t` = 0001, 0010, 0100, 1000 in cycles k+1..k+4. `done`=1 at k+5, `busy` low at k+5, IDLE at k+6.
- Mask=0101, loop_count=3: `t` sequence 0001, 0100 repeated 3×, with `pass_idx` 0, 0, 1, 1, 2, 2. Single `done` pulse after the sixth strobe.
- Mask=1111, `hold`=1 for 3 cycles starting while T1 is current: `t`=0000 for those 3 cycles, then 0010, 0100, 1000. `done` is 3 cycles later than the unheld case.
- `start` pulsed during RUN and during the DONE cycle: ignored, with no extra pass. `start` in the following IDLE cycle is accepted.
- `rst_n`=0 during T2 of pass 1: next cycle `t`=0000, `busy`=0, `done`=0, `pass_idx`=0. No `done` pulse is emitted.
- Mask=0000, loop_count=5 with macro defined: `done`=1 the cycle after start, `t` stays 0000. Without the macro, the same stimulus runs 5 full T0..T3 passes.
